// File: rtl/sequence_scorer.sv
// sequence_scorer
//   Compares a user-entered symbol sequence against the expected sequence and
//   reports a match count (point_score), a Kendall inversion distance and a
//   registered pass/fail verdict. One compare per clock, start/done handshake.
//
//   Ports:
//     clock, reset      system clock, synchronous active-high reset
//     start             single-cycle request, accepted only in IDLE or DONE
//     expected_seq      ROUNDS symbols, element k at [k*SYM_W +: SYM_W]
//     input_seq         user symbols, same packing
//     busy              high in LOAD/MATCH/INVERT/DECIDE
//     done              level, high in DONE until next accepted start / reset
//     pass, fail        registered verdict and its complement (0 until decided)
//     point_score       number of matched expected symbols
//     kendall_distance  number of order inversions among matched symbols
//
//   Optional feature macro: SEQUENCE_SCORER_EARLY_EXIT_EN
//     When defined, a run whose match count is already below MIN_SCORE at the
//     end of MATCH skips INVERT and goes straight to DECIDE (distance reads 0).
//
//   Cycle budget: the accepting edge latches the operands, and the LOAD cycle
//   carries the first (0,0) comparison, so the ROUNDS*ROUNDS compares occupy
//   LOAD plus ROUNDS*ROUNDS-1 MATCH cycles. done therefore rises
//   1 + ROUNDS^2 + ROUNDS*(ROUNDS-1)/2 edges after the accepting edge.
module sequence_scorer #(
  parameter int ROUNDS         = 6,
  parameter int SYM_W          = 5,
  parameter int MIN_SCORE      = 5,
  parameter int MAX_INVERSIONS = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [ROUNDS*SYM_W-1:0]                       expected_seq,
  input  logic [ROUNDS*SYM_W-1:0]                       input_seq,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          pass,
  output logic                                          fail,
  output logic [$clog2(ROUNDS+1)-1:0]                   point_score,
  output logic [$clog2(ROUNDS*(ROUNDS-1)/2+1)-1:0]      kendall_distance
);

  localparam int PAIRS = ROUNDS * (ROUNDS - 1) / 2;
  localparam int SC_W  = $clog2(ROUNDS + 1);
  localparam int KD_W  = $clog2(PAIRS + 1);
  localparam int IW    = $clog2(ROUNDS);
  localparam int PW    = $clog2(ROUNDS + 1);

  localparam logic [IW-1:0] LAST      = IW'(ROUNDS - 1);
  localparam logic [IW-1:0] PENULT    = IW'(ROUNDS - 2);
  // Position value for an expected symbol that found no partner; it is larger
  // than any real index, so it can never be the smaller side of an inversion.
  localparam logic [PW-1:0] NOT_FOUND = PW'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MATCH, S_INVERT, S_DECIDE, S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [ROUNDS-1:0][SYM_W-1:0]    exp_q, exp_d;
  logic [ROUNDS-1:0][SYM_W-1:0]    inp_q, inp_d;
  logic [ROUNDS-1:0][PW-1:0]       pos_q, pos_d;
  logic [ROUNDS-1:0]               used_q, used_d;
  logic [IW-1:0]                   i_q, i_d;
  logic [IW-1:0]                   j_q, j_d;
  logic [SC_W-1:0]                 score_q, score_d;
  logic [KD_W-1:0]                 kd_q, kd_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            pass_q, pass_d;
  logic                            fail_q, fail_d;
  logic                            verdict;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    inp_d   = inp_q;
    pos_d   = pos_q;
    used_d  = used_q;
    i_d     = i_q;
    j_d     = j_q;
    score_d = score_q;
    kd_d    = kd_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    verdict = (int'(score_q) >= MIN_SCORE) && (int'(kd_q) <= MAX_INVERSIONS);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          exp_d   = expected_seq;
          inp_d   = input_seq;
          pos_d   = {ROUNDS{NOT_FOUND}};
          used_d  = '0;
          i_d     = '0;
          j_d     = '0;
          score_d = '0;
          kd_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end

      S_LOAD, S_MATCH: begin
        // Greedy pairing: each expected symbol claims the lowest unused input
        // slot holding the same value; later j for the same i are no-ops.
        if (pos_q[i_q] == NOT_FOUND && !used_q[j_q] && inp_q[j_q] == exp_q[i_q]) begin
          pos_d[i_q]  = PW'(j_q);
          used_d[j_q] = 1'b1;
          score_d     = score_q + SC_W'(1);
        end
        state_d = S_MATCH;
        if (i_q == LAST && j_q == LAST) begin
          state_d = S_INVERT;
          i_d     = '0;
          j_d     = IW'(1);
`ifdef SEQUENCE_SCORER_EARLY_EXIT_EN
          if (int'(score_d) < MIN_SCORE) state_d = S_DECIDE;
`endif
        end else if (j_q == LAST) begin
          i_d = i_q + IW'(1);
          j_d = '0;
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      S_INVERT: begin
        if (pos_q[i_q] != NOT_FOUND && pos_q[i_q] > pos_q[j_q])
          kd_d = kd_q + KD_W'(1);
        if (i_q == PENULT && j_q == LAST) begin
          state_d = S_DECIDE;
        end else if (j_q == LAST) begin
          i_d = i_q + IW'(1);
          j_d = i_q + IW'(2);
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      S_DECIDE: begin
        pass_d  = verdict;
        fail_d  = !verdict;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_MATCH) ||
             (state_d == S_INVERT) || (state_d == S_DECIDE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      inp_q   <= '0;
      pos_q   <= '0;
      used_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      score_q <= '0;
      kd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      inp_q   <= inp_d;
      pos_q   <= pos_d;
      used_q  <= used_d;
      i_q     <= i_d;
      j_q     <= j_d;
      score_q <= score_d;
      kd_q    <= kd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail             = fail_q;
  assign point_score      = score_q;
  assign kendall_distance = kd_q;

endmodule

// File: tb/tb_sequence_scorer.sv
// Bench for sequence_scorer: directed cases plus randomized sequences scored
// by a plain greedy-match / pair-count reference model.
module tb_sequence_scorer;
  localparam int R       = 6;
  localparam int W       = 5;
  localparam int MIN_SC  = 5;
  localparam int MAX_INV = 2;
  localparam int SC_W    = $clog2(R + 1);
  localparam int KD_W    = $clog2(R * (R - 1) / 2 + 1);
  localparam int LAT_FULL  = 1 + R * R + R * (R - 1) / 2;
  localparam int LAT_EARLY = 1 + R * R;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [R*W-1:0]   expected_seq;
  logic [R*W-1:0]   input_seq;
  logic             busy, done, pass, fail;
  logic [SC_W-1:0]  point_score;
  logic [KD_W-1:0]  kendall_distance;

  int checks   = 0;
  int failures = 0;

  sequence_scorer #(.ROUNDS(R), .SYM_W(W), .MIN_SCORE(MIN_SC), .MAX_INVERSIONS(MAX_INV)) dut (
    .clock(clock), .reset(reset), .start(start),
    .expected_seq(expected_seq), .input_seq(input_seq),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .point_score(point_score), .kendall_distance(kendall_distance)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [R*W-1:0] pack(input int s[R]);
    logic [R*W-1:0] p;
    p = '0;
    for (int k = 0; k < R; k++) p[k*W +: W] = W'(s[k]);
    return p;
  endfunction

  // Reference: each expected symbol takes the first still-free equal input
  // slot; distance counts matched pairs whose input positions are reversed.
  task automatic model(input logic [R*W-1:0] ex, input logic [R*W-1:0] in,
                       output int sc, output int kd, output int lat);
    int pos[R];
    bit taken[R];
    sc = 0;
    kd = 0;
    for (int k = 0; k < R; k++) begin pos[k] = -1; taken[k] = 0; end
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        if (!taken[b] && in[b*W +: W] == ex[a*W +: W]) begin
          pos[a] = b; taken[b] = 1; sc++;
          break;
        end
    for (int a = 0; a < R; a++)
      for (int b = a + 1; b < R; b++)
        if (pos[a] >= 0 && pos[b] >= 0 && pos[a] > pos[b]) kd++;
    lat = LAT_FULL;
`ifdef SEQUENCE_SCORER_EARLY_EXIT_EN
    if (sc < MIN_SC) begin kd = 0; lat = LAT_EARLY; end
`endif
  endtask

  // One full run; optionally pulses a spurious start mid-run with different data.
  task automatic run(input string tag, input logic [R*W-1:0] ex, input logic [R*W-1:0] in,
                     input bit poke);
    int sc, kd, lat, got_lat;
    bit ok;
    model(ex, in, sc, kd, lat);
    ok = (sc >= MIN_SC) && (kd <= MAX_INV);
    @(negedge clock);
    expected_seq = ex;
    input_seq    = in;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, ".acc_busy"}, busy, 1);
    check({tag, ".acc_done"}, done, 0);
    check({tag, ".acc_pass"}, pass, 0);
    check({tag, ".acc_fail"}, fail, 0);
    check({tag, ".acc_kd"}, kendall_distance, 0);
    got_lat = 0;
    for (int c = 1; c <= LAT_FULL + 10; c++) begin
      if (poke && c == 10) begin
        start        = 1'b1;
        expected_seq = ~ex;
        input_seq    = '0;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin got_lat = c; break; end
    end
    check({tag, ".latency"}, got_lat, lat);
    check({tag, ".score"}, point_score, sc);
    check({tag, ".dist"}, kendall_distance, kd);
    check({tag, ".pass"}, pass, ok);
    check({tag, ".fail"}, fail, !ok);
    check({tag, ".busy_done"}, busy, 0);
    repeat (3) @(posedge clock);
    #1;
    check({tag, ".hold_done"}, done, 1);
    check({tag, ".hold_score"}, point_score, sc);
    check({tag, ".hold_dist"}, kendall_distance, kd);
  endtask

  initial begin
    int d[R];
    int t[R];
    int tmp, a;
    reset        = 1'b1;
    start        = 1'b0;
    expected_seq = '0;
    input_seq    = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.fail", fail, 0);
    check("rst.score", point_score, 0);
    check("rst.dist", kendall_distance, 0);
    reset = 1'b0;

    d = '{1, 2, 3, 4, 5, 6};
    t = '{1, 2, 3, 4, 5, 6};
    run("ident", pack(d), pack(t), 0);
    t = '{2, 1, 3, 4, 6, 5};
    run("swap2", pack(d), pack(t), 0);
    t = '{3, 2, 1, 4, 5, 6};
    run("rev3", pack(d), pack(t), 0);
    t = '{1, 2, 3, 4, 9, 9};
    run("miss2", pack(d), pack(t), 0);
    t = '{7, 7, 1, 2, 3, 4};
    d = '{7, 1, 2, 3, 4, 7};
    run("dups", pack(t), pack(d), 0);
    d = '{1, 2, 3, 4, 5, 6};
    t = '{2, 1, 3, 4, 6, 5};
    run("poke", pack(d), pack(t), 1);

    // Reset in the middle of a run.
    @(negedge clock);
    expected_seq = pack(d);
    input_seq    = pack(d);
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst.busy", busy, 0);
    check("mid_rst.done", done, 0);
    check("mid_rst.pass", pass, 0);
    check("mid_rst.fail", fail, 0);
    check("mid_rst.score", point_score, 0);
    check("mid_rst.dist", kendall_distance, 0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_rst.idle_busy", busy, 0);
    check("mid_rst.idle_done", done, 0);

    run("after_rst", pack(d), pack(d), 0);

    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < R; k++) d[k] = int'($urandom_range(0, 7));
      t = d;
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        a        = int'($urandom_range(0, R - 2));
        tmp      = t[a];
        t[a]     = t[a + 1];
        t[a + 1] = tmp;
      end
      if ($urandom_range(0, 2) == 0) t[$urandom_range(0, R - 1)] = int'($urandom_range(0, 31));
      run($sformatf("rnd%0d", n), pack(d), pack(t), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
